riscv_mem_sys: RTL and testbench

Memory responder for the pipelined RV32I core. It implements the target end of both of the core's memory interfaces:
- Instruction port: IADDR in, IDATA/IVALID out, with programmable wait states.
- Data port: DADDR/DATAO/DWE/DRE/DSE in, DATAI out, with byte-lane steering and load sign extension.
- TOHOST halt register and a loader port that writes the program image before and during run.

---
 rtl/riscv_mem_sys_if.sv | 31 +++
 rtl/riscv_mem_sys.sv | 186 ++++++++++++++++++
 tb/tb_riscv_mem_sys.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_sys_if.sv
// Bus bundle between the RV32I core (master) and its memory responder (slave).
// No valid/ready pair: IVALID qualifies IDATA for the current IADDR, and DATAI is fixed-latency (one cycle after DRE).
interface riscv_mem_sys_if;
  logic [31:0] IADDR;
  logic [31:0] IDATA;
  logic        IVALID;
  logic [31:0] DADDR;
  logic [31:0] DATAO;
  logic [1:0]  DWE;
  logic [1:0]  DRE;
  logic        DSE;
  logic [31:0] DATAI;
  logic        LD_WE;
  logic        LD_SEL;
  logic [31:0] LD_ADDR;
  logic [31:0] LD_DATA;
  logic [31:0] TOHOST;
  logic        HALT;
  logic        MISALIGN;
  logic [1:0]  istate;

  modport master (
    output IADDR, DADDR, DATAO, DWE, DRE, DSE, LD_WE, LD_SEL, LD_ADDR, LD_DATA,
    input  IDATA, IVALID, DATAI, TOHOST, HALT, MISALIGN, istate
  );

  modport slave (
    input  IADDR, DADDR, DATAO, DWE, DRE, DSE, LD_WE, LD_SEL, LD_ADDR, LD_DATA,
    output IDATA, IVALID, DATAI, TOHOST, HALT, MISALIGN, istate
  );
endinterface

// File: rtl/riscv_mem_sys.sv
// Instruction/data memory responder for the pipelined RV32I core, with TOHOST halt
// register, wait-state instruction FSM and a program loader port.
module riscv_mem_sys #(
  parameter int          IMEM_AW     = 12,
  parameter int          DMEM_AW     = 12,
  parameter int          IWAIT       = 0,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_F000
) (
  input logic            CLK,
  input logic            RST,
  riscv_mem_sys_if.slave bus
);

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_WAIT = 2'd1, S_VALID = 2'd2} istate_t;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [3:0]  WAIT_INIT = 4'(IWAIT - 1);

  logic [31:0] imem [0:(1 << IMEM_AW) - 1];
  logic [31:0] dmem [0:(1 << DMEM_AW) - 1];

  // ---------------- instruction port ----------------
  istate_t     state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] last_q, last_d;
  logic [31:0] idata_q, idata_d;
  logic        ivalid_q, ivalid_d;
  logic [31:0] ifetch;

  // In WAIT the fetch only completes while IADDR==last_addr, so one read port on IADDR serves both modes.
  assign ifetch = imem[bus.IADDR[IMEM_AW+1:2]];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    idata_d  = idata_q;
    ivalid_d = ivalid_q;
    if (IWAIT == 0) begin
      idata_d  = ifetch;
      ivalid_d = 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          last_d   = bus.IADDR;
          cnt_d    = WAIT_INIT;
          ivalid_d = 1'b0;
          state_d  = S_WAIT;
        end
        S_WAIT: begin
          if (bus.IADDR != last_q) begin
            last_d   = bus.IADDR;
            cnt_d    = WAIT_INIT;
            ivalid_d = 1'b0;
          end else if (cnt_q == 4'd0) begin
            idata_d  = ifetch;
            ivalid_d = 1'b1;
            state_d  = S_VALID;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_VALID: begin
          if (bus.IADDR != last_q) begin
            ivalid_d = 1'b0;
            last_d   = bus.IADDR;
            cnt_d    = WAIT_INIT;
            state_d  = S_WAIT;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_FETCH;
      cnt_q    <= 4'd0;
      last_q   <= 32'd0;
      idata_q  <= NOP;
      ivalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      idata_q  <= idata_d;
      ivalid_q <= ivalid_d;
    end
  end

  // ---------------- data port ----------------
  logic [DMEM_AW-1:0] didx, lidx_d;
  logic [IMEM_AW-1:0] lidx_i;
  logic               th_hit, wr_mis, rd_mis, wr_en, rd_en;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic [31:0]        rd_word, tohost_q, datai, rd_shift;
  logic [15:0]        rd_half;
  logic [1:0]         rd_lane, rd_size;
  logic               rd_sext, halt_q, mis_q;
  logic               ld_addr_unused;

  assign didx           = bus.DADDR[DMEM_AW+1:2];
  assign lidx_d         = bus.LD_ADDR[DMEM_AW+1:2];
  assign lidx_i         = bus.LD_ADDR[IMEM_AW+1:2];
  assign ld_addr_unused = ^bus.LD_ADDR;

  always_comb begin
    th_hit = (bus.DADDR[31:2] == TOHOST_ADDR[31:2]);
    wr_mis = (bus.DWE == 2'b10 && bus.DADDR[0]) || (bus.DWE == 2'b11 && bus.DADDR[1:0] != 2'b00);
    rd_mis = (bus.DRE == 2'b10 && bus.DADDR[0]) || (bus.DRE == 2'b11 && bus.DADDR[1:0] != 2'b00);
    wr_en  = (bus.DWE != 2'b00) && !wr_mis;
    // A store in the same cycle takes priority; the read then returns zero.
    rd_en  = (bus.DRE != 2'b00) && (bus.DWE == 2'b00) && !rd_mis;
    be     = 4'b0000;
    wdata  = bus.DATAO;
    case (bus.DWE)
      2'b01: begin
        be    = 4'b0001 << bus.DADDR[1:0];
        wdata = {4{bus.DATAO[7:0]}};
      end
      2'b10: begin
        be    = bus.DADDR[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.DATAO[15:0]}};
      end
      2'b11:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Loader assignment comes last so it overrides a core store to the same word.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en && !th_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) dmem[didx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (bus.LD_WE && bus.LD_SEL)  dmem[lidx_d] <= bus.LD_DATA;
    if (bus.LD_WE && !bus.LD_SEL) imem[lidx_i] <= bus.LD_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_word  <= 32'd0;
      rd_lane  <= 2'b00;
      rd_size  <= 2'b11;
      rd_sext  <= 1'b0;
      tohost_q <= 32'd0;
      halt_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      if (bus.DRE != 2'b00) begin
        rd_word <= !rd_en ? 32'd0 :
                   (bus.DRE == 2'b11 && th_hit) ? tohost_q : dmem[didx];
        rd_lane <= bus.DADDR[1:0];
        rd_size <= bus.DRE;
        rd_sext <= bus.DSE;
      end
      if (wr_mis || rd_mis) mis_q <= 1'b1;
      if (wr_en && th_hit && bus.DWE == 2'b11) begin
        tohost_q <= bus.DATAO;
        if (bus.DATAO != 32'd0) halt_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_shift = rd_word >> {rd_lane, 3'b000};
    rd_half  = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (rd_size)
      2'b01:   datai = {{24{rd_sext & rd_shift[7]}}, rd_shift[7:0]};
      2'b10:   datai = {{16{rd_sext & rd_half[15]}}, rd_half};
      default: datai = rd_word;
    endcase
  end

  assign bus.IDATA    = idata_q;
  assign bus.IVALID   = ivalid_q;
  assign bus.DATAI    = datai;
  assign bus.TOHOST   = tohost_q;
  assign bus.HALT     = halt_q;
  assign bus.MISALIGN = mis_q;
  assign bus.istate   = state_q;

endmodule

// File: tb/tb_riscv_mem_sys.sv
// Bench for riscv_mem_sys: directed vector table, hand-written wait-state/reset sequences,
// and random traffic checked against a byte-level memory model.
module tb_riscv_mem_sys;
  localparam logic [31:0] TH  = 32'h0000_F000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset / DUTs ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr0, iaddr3, daddr, datao, ld_addr, ld_data;
  logic [1:0]  dwe, dre;
  logic        dse, ld_we, ld_sel;

  always #5 clk = ~clk;

  riscv_mem_sys_if b0 ();
  riscv_mem_sys_if b3 ();

  assign b0.IADDR = iaddr0;   assign b3.IADDR = iaddr3;
  assign b0.DADDR = daddr;    assign b3.DADDR = daddr;
  assign b0.DATAO = datao;    assign b3.DATAO = datao;
  assign b0.DWE = dwe;        assign b3.DWE = dwe;
  assign b0.DRE = dre;        assign b3.DRE = dre;
  assign b0.DSE = dse;        assign b3.DSE = dse;
  assign b0.LD_WE = ld_we;    assign b3.LD_WE = ld_we;
  assign b0.LD_SEL = ld_sel;  assign b3.LD_SEL = ld_sel;
  assign b0.LD_ADDR = ld_addr; assign b3.LD_ADDR = ld_addr;
  assign b0.LD_DATA = ld_data; assign b3.LD_DATA = ld_data;

  riscv_mem_sys #(.IWAIT(0)) u_dut0 (.CLK(clk), .RST(rst), .bus(b0.slave));
  riscv_mem_sys #(.IWAIT(3)) u_dut3 (.CLK(clk), .RST(rst), .bus(b3.slave));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mbyte [0:16383];
  logic [31:0] imod [0:15];
  logic [31:0] m_datai, m_tohost, m_idata0;
  logic        m_halt, m_mis, m_ivalid0;

  function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd2 && a[0]) || (sz == 2'd3 && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] sz, input logic se);
    int n;
    logic [31:0] base, v;
    n = nbytes(sz);
    base = a & ~32'(n - 1);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mbyte[(base + 32'(i)) & 32'h3FFF]) << (8 * i));
    if (se && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Advances the model by one clock using the inputs currently driven.
  task automatic mdl_step();
    logic wm, rm, th;
    int n;
    logic [31:0] base;
    if (rst) begin
      m_datai = 32'd0; m_tohost = 32'd0; m_halt = 1'b0; m_mis = 1'b0;
      m_idata0 = NOP; m_ivalid0 = 1'b0;
    end else begin
      m_idata0  = imod[iaddr0[5:2]];
      m_ivalid0 = 1'b1;
      wm = misal(dwe, daddr);
      rm = misal(dre, daddr);
      th = (daddr[31:2] == TH[31:2]);
      if (dre != 2'd0)
        m_datai = (dwe != 2'd0 || rm) ? 32'd0 :
                  (dre == 2'd3 && th) ? m_tohost : mdl_load(daddr, dre, dse);
      if (wm || rm) m_mis = 1'b1;
      if (dwe != 2'd0 && !wm) begin
        if (th) begin
          if (dwe == 2'd3) begin
            m_tohost = datao;
            if (datao != 32'd0) m_halt = 1'b1;
          end
        end else begin
          n = nbytes(dwe);
          base = daddr & ~32'(n - 1);
          for (int i = 0; i < n; i++) mbyte[(base + 32'(i)) & 32'h3FFF] = datao[8*i +: 8];
        end
      end
    end
    if (ld_we) begin
      if (ld_sel) begin
        for (int i = 0; i < 4; i++) mbyte[{18'd0, ld_addr[13:2], 2'b00} + i] = ld_data[8*i +: 8];
      end else begin
        imod[ld_addr[5:2]] = ld_data;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dwe = 2'd0; dre = 2'd0; dse = 1'b0; datao = 32'd0; ld_we = 1'b0;
  endtask

  task automatic load(input logic sel, input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  task automatic check_data(input string tag);
    check({tag, "_datai"},  b0.DATAI,    m_datai);
    check({tag, "_tohost"}, b0.TOHOST,   m_tohost);
    check({tag, "_halt"},   32'(b0.HALT),     32'(m_halt));
    check({tag, "_mis"},    32'(b0.MISALIGN), 32'(m_mis));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  dwe, dre;
    logic        dse;
    logic [31:0] daddr, datao, e_datai, e_tohost;
    logic        e_mis, e_halt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] w, input logic [1:0] r, input logic s,
                              input logic [31:0] a, input logic [31:0] d, input logic [31:0] ed,
                              input logic em, input logic [31:0] et, input logic eh);
    vec_t v;
    v.dwe = w; v.dre = r; v.dse = s; v.daddr = a; v.datao = d;
    v.e_datai = ed; v.e_mis = em; v.e_tohost = et; v.e_halt = eh;
    return v;
  endfunction

  initial begin
    //               dwe   dre   dse addr      data          datai         mis tohost halt
    tbl.push_back(mk(2'd0, 2'd1, 1, 32'h100, 32'h0,         32'hFFFF_FFF3, 0, 32'd0, 0));
    tbl.push_back(mk(2'd0, 2'd1, 0, 32'h101, 32'h0,         32'h0000_00F2, 0, 32'd0, 0));
    tbl.push_back(mk(2'd0, 2'd2, 1, 32'h102, 32'h0,         32'hFFFF_8081, 0, 32'd0, 0));
    tbl.push_back(mk(2'd0, 2'd3, 0, 32'h100, 32'h0,         32'h8081_F2F3, 0, 32'd0, 0));
    tbl.push_back(mk(2'd0, 2'd2, 0, 32'h100, 32'h0,         32'h0000_F2F3, 0, 32'd0, 0));
    tbl.push_back(mk(2'd0, 2'd1, 1, 32'h103, 32'h0,         32'hFFFF_FF80, 0, 32'd0, 0));
    tbl.push_back(mk(2'd3, 2'd0, 0, 32'h200, 32'h1122_3344, 32'hFFFF_FF80, 0, 32'd0, 0));
    tbl.push_back(mk(2'd1, 2'd0, 0, 32'h201, 32'h0000_00AA, 32'hFFFF_FF80, 0, 32'd0, 0));
    tbl.push_back(mk(2'd0, 2'd3, 0, 32'h200, 32'h0,         32'h1122_AA44, 0, 32'd0, 0));
    tbl.push_back(mk(2'd2, 2'd0, 0, 32'h202, 32'h0000_5566, 32'h1122_AA44, 0, 32'd0, 0));
    tbl.push_back(mk(2'd0, 2'd3, 0, 32'h200, 32'h0,         32'h5566_AA44, 0, 32'd0, 0));
    tbl.push_back(mk(2'd3, 2'd0, 0, 32'h300, 32'hCAFE_BABE, 32'h5566_AA44, 0, 32'd0, 0));
    tbl.push_back(mk(2'd0, 2'd2, 1, 32'h301, 32'h0,         32'h0,         1, 32'd0, 0));
    tbl.push_back(mk(2'd3, 2'd0, 0, 32'h302, 32'hDEAD_BEEF, 32'h0,         1, 32'd0, 0));
    tbl.push_back(mk(2'd0, 2'd3, 0, 32'h300, 32'h0,         32'hCAFE_BABE, 1, 32'd0, 0));
    tbl.push_back(mk(2'd3, 2'd3, 0, 32'h300, 32'h1234_5678, 32'h0,         1, 32'd0, 0));
    tbl.push_back(mk(2'd0, 2'd3, 0, 32'h300, 32'h0,         32'h1234_5678, 1, 32'd0, 0));
    tbl.push_back(mk(2'd3, 2'd0, 0, TH,      32'h0,         32'h1234_5678, 1, 32'd0, 0));
    tbl.push_back(mk(2'd3, 2'd0, 0, TH,      32'h1,         32'h1234_5678, 1, 32'd1, 1));
    tbl.push_back(mk(2'd0, 2'd3, 0, TH,      32'h0,         32'h1,         1, 32'd1, 1));
    tbl.push_back(mk(2'd1, 2'd0, 0, TH,      32'hFF,        32'h1,         1, 32'd1, 1));
    tbl.push_back(mk(2'd3, 2'd0, 0, TH,      32'h0,         32'h1,         1, 32'd0, 1));
    tbl.push_back(mk(2'd0, 2'd3, 0, TH,      32'h0,         32'h0,         1, 32'd0, 1));
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] w;
    int sz;
    rst = 1'b1; iaddr0 = 32'd0; iaddr3 = 32'h10; daddr = 32'd0; ld_sel = 1'b0;
    ld_addr = 32'd0; ld_data = 32'd0;
    idle();
    m_datai = 32'd0; m_tohost = 32'd0; m_halt = 1'b0; m_mis = 1'b0;
    m_idata0 = NOP; m_ivalid0 = 1'b0;

    // Program image loaded while RST is held.
    for (int i = 0; i < 16; i++) load(1'b0, 32'(i) << 2, $urandom());
    for (int i = 0; i < 512; i++)
      load(1'b1, 32'(i) << 2, (i == 32'h40) ? 32'h8081_F2F3 : $urandom());

    check("rst_idata0",  b0.IDATA, NOP);
    check("rst_idata3",  b3.IDATA, NOP);
    check("rst_ivalid0", 32'(b0.IVALID), 32'd0);
    check("rst_ivalid3", 32'(b3.IVALID), 32'd0);
    check("rst_datai",   b0.DATAI, 32'd0);
    check("rst_tohost",  b0.TOHOST, 32'd0);
    check("rst_halt",    32'(b0.HALT), 32'd0);
    check("rst_mis",     32'(b0.MISALIGN), 32'd0);

    // Wait states: address held from the first cycle out of reset.
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("iw3_first_valid", 32'(b3.IVALID), (e == 4) ? 32'd1 : 32'd0);
    end
    check("iw3_first_data", b3.IDATA, imod[4]);
    iaddr3 = 32'h14;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("iw3_next_valid", 32'(b3.IVALID), (e == 4) ? 32'd1 : 32'd0);
    end
    check("iw3_next_data", b3.IDATA, imod[5]);

    // Zero wait states: back-to-back stream.
    for (int k = 0; k < 4; k++) begin
      iaddr0 = 32'(k) << 2;
      exp_q.push_back(imod[k]);
      step();
      check("iw0_stream_data", b0.IDATA, exp_q.pop_front());
      check("iw0_stream_valid", 32'(b0.IVALID), 32'd1);
    end

    // Data-port vector table.
    foreach (tbl[i]) begin
      dwe = tbl[i].dwe; dre = tbl[i].dre; dse = tbl[i].dse;
      daddr = tbl[i].daddr; datao = tbl[i].datao;
      step();
      check("tbl_datai",  b0.DATAI, tbl[i].e_datai);
      check("tbl_mis",    32'(b0.MISALIGN), 32'(tbl[i].e_mis));
      check("tbl_tohost", b0.TOHOST, tbl[i].e_tohost);
      check("tbl_halt",   32'(b0.HALT), 32'(tbl[i].e_halt));
    end
    idle();

    // Loader and core store hit the same word in one cycle.
    dwe = 2'd3; daddr = 32'h204; datao = 32'hAAAA_AAAA;
    ld_we = 1'b1; ld_sel = 1'b1; ld_addr = 32'h204; ld_data = 32'h5555_1234;
    step();
    idle();
    dre = 2'd3; daddr = 32'h204;
    step();
    check("ld_wins", b0.DATAI, 32'h5555_1234);
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      iaddr0 = 32'($urandom_range(0, 15)) << 2;
      idle();
      daddr = 32'($urandom_range(0, 32'h7FF));
      datao = $urandom();
      dse = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: dwe = 2'($urandom_range(1, 3));
        1: dre = 2'($urandom_range(1, 3));
        2: begin dwe = 2'($urandom_range(1, 3)); dre = 2'($urandom_range(1, 3)); end
        default: ;
      endcase
      sz = (dwe > dre) ? int'(dwe) : int'(dre);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3) daddr[1:0] = 2'b00;
        else if (sz == 2) daddr[0] = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        daddr = TH;
        if (dre != 2'd0) dre = 2'd3;
        case ($urandom_range(0, 2))
          0: datao = 32'd0;
          1: datao = 32'd1;
          default: ;
        endcase
      end
      if ($urandom_range(0, 7) == 0) begin
        ld_we = 1'b1;
        ld_sel = 1'($urandom_range(0, 1));
        ld_addr = ld_sel ? ((daddr < 32'h800 && $urandom_range(0, 1) == 1) ? daddr : 32'($urandom_range(0, 511)) << 2)
                         : 32'($urandom_range(0, 15)) << 2;
        ld_addr[1:0] = 2'b00;
        ld_data = $urandom();
      end
      step();
      check_data("rnd");
      check("rnd_idata",  b0.IDATA, m_idata0);
      check("rnd_ivalid", 32'(b0.IVALID), 32'(m_ivalid0));
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 6; i++) step();
    check("pre_rst_ivalid3", 32'(b3.IVALID), 32'd1);

    // Make the sticky flags and TOHOST nonzero before the mid-run reset.
    dwe = 2'd3; daddr = TH; datao = 32'h77;
    step();
    dwe = 2'd0; dre = 2'd3; daddr = 32'h001;
    step();
    check("pre_rst_mis", 32'(b0.MISALIGN), 32'd1);
    check("pre_rst_halt", 32'(b0.HALT), 32'd1);
    idle();

    // Reset while the wait FSM is counting; store in the reset cycle must be dropped.
    iaddr3 = 32'h18;
    step();
    check("mid_wait_ivalid3", 32'(b3.IVALID), 32'd0);
    w = mdl_load(32'h208, 2'd3, 1'b0);
    rst = 1'b1; dwe = 2'd3; daddr = 32'h208; datao = ~w;
    step();
    check("mid_rst_ivalid3", 32'(b3.IVALID), 32'd0);
    check("mid_rst_idata3",  b3.IDATA, NOP);
    check("mid_rst_state3",  32'(b3.istate), 32'd0);
    check_data("mid_rst");
    dwe = 2'd0; dre = 2'd3; daddr = 32'h100;
    step();
    check("rst_read_drop", b0.DATAI, 32'd0);
    rst = 1'b0; dre = 2'd3; daddr = 32'h208;
    step();
    check("rst_store_drop", b0.DATAI, w);
    check_data("post_rst");
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
